// File: rtl/pacote_memoria.sv
// Shared types and constants for the load/store unit and its timeout counter.
package pacote_memoria;

    localparam int unsigned LARGURA_DADO   = 32;
    localparam int unsigned LARGURA_MEIA   = 16;
    localparam int unsigned LARGURA_CONT   = 8;
    localparam int unsigned TIMEOUT_PADRAO = 16;

    localparam logic TAM_MEIA    = 1'b0;
    localparam logic TAM_PALAVRA = 1'b1;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ACESSO0   = 2'd1,
        ACESSO1   = 2'd2,
        CONCLUIDO = 2'd3
    } estado_t;

    typedef struct packed {
        logic                    escrita;
        logic                    tamanho;
        logic [LARGURA_DADO-1:0] endereco;
        logic [LARGURA_DADO-1:0] dado;
    } pedido_t;

    // Halfwords need bit 0 clear; words need both low bits clear.
    function automatic logic desalinhado(input logic tamanho, input logic [1:0] endereco_baixo);
        if (tamanho == TAM_MEIA) begin
            return endereco_baixo[0];
        end
        return endereco_baixo != 2'b00;
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// Counts cycles spent waiting for a memory ack; expired flags the last allowed cycle.
module contador_timeout
    import pacote_memoria::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [LARGURA_CONT-1:0] limit,
    output logic                    expired
);

    logic [LARGURA_CONT-1:0] contagem;

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (enable && !expired) begin
            contagem <= contagem + LARGURA_CONT'(1);
        end
    end

    // Asserted during the limit-th wait cycle so an ack in that same cycle still wins.
    assign expired = enable && (contagem >= (limit - LARGURA_CONT'(1)));

endmodule

// File: rtl/unidade_load_store.sv
// Load/store unit: splits 16/32-bit CPU accesses into halfword memory transactions.
module unidade_load_store
    import pacote_memoria::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_escrita,
    input  logic                    cpu_tamanho,
    input  logic [LARGURA_DADO-1:0] cpu_endereco,
    input  logic [LARGURA_DADO-1:0] cpu_dado,
    output logic                    cpu_ocupado,
    output logic                    cpu_pronto,
    output logic                    cpu_erro,
    output logic [LARGURA_DADO-1:0] cpu_dado_lido,
    output logic                    mem_req,
    output logic                    mem_escrita,
    output logic [LARGURA_DADO-1:0] mem_endereco,
    output logic [LARGURA_MEIA-1:0] mem_dado_escrita,
    input  logic                    mem_ack,
    input  logic [LARGURA_MEIA-1:0] mem_dado_leitura
);

    localparam logic [LARGURA_CONT-1:0] LIMITE = LARGURA_CONT'(TIMEOUT_CICLOS);

    estado_t                 estado;
    estado_t                 proximo;
    pedido_t                 pedido;
    logic [LARGURA_MEIA-1:0] metade_baixa;
    logic                    em_acesso;
    logic                    limpar;
    logic                    expirou;

    assign em_acesso = (estado == ACESSO0) || (estado == ACESSO1);
    assign limpar    = (proximo != estado);

    contador_timeout u_contador (
        .clock   (clock),
        .reset   (reset),
        .clear   (limpar),
        .enable  (em_acesso),
        .limit   (LIMITE),
        .expired (expirou)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO: begin
                if (cpu_req) begin
                    proximo = desalinhado(cpu_tamanho, cpu_endereco[1:0]) ? CONCLUIDO : ACESSO0;
                end
            end
            ACESSO0: begin
                if (mem_ack) begin
                    proximo = (pedido.tamanho == TAM_PALAVRA) ? ACESSO1 : CONCLUIDO;
                end else if (expirou) begin
                    proximo = CONCLUIDO;
                end
            end
            ACESSO1: begin
                if (mem_ack || expirou) begin
                    proximo = CONCLUIDO;
                end
            end
            CONCLUIDO: proximo = OCIOSO;
            default:   proximo = OCIOSO;
        endcase
    end

    always_comb begin
        mem_req          = 1'b0;
        mem_escrita      = 1'b0;
        mem_endereco     = '0;
        mem_dado_escrita = '0;
        cpu_ocupado      = (estado != OCIOSO);
        cpu_pronto       = (estado == CONCLUIDO);
        case (estado)
            ACESSO0: begin
                mem_req          = 1'b1;
                mem_escrita      = pedido.escrita;
                mem_endereco     = pedido.endereco;
                mem_dado_escrita = pedido.dado[LARGURA_MEIA-1:0];
            end
            ACESSO1: begin
                mem_req          = 1'b1;
                mem_escrita      = pedido.escrita;
                mem_endereco     = pedido.endereco + LARGURA_DADO'(2);
                mem_dado_escrita = pedido.dado[LARGURA_DADO-1:LARGURA_MEIA];
            end
            default: ;
        endcase
    end

    // Request latch and result capture; results hold until the next accepted request.
    always_ff @(posedge clock) begin
        if (reset) begin
            pedido        <= '0;
            metade_baixa  <= '0;
            cpu_erro      <= 1'b0;
            cpu_dado_lido <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (cpu_req) begin
                        pedido.escrita  <= cpu_escrita;
                        pedido.tamanho  <= cpu_tamanho;
                        pedido.endereco <= cpu_endereco;
                        pedido.dado     <= cpu_dado;
                        cpu_erro        <= desalinhado(cpu_tamanho, cpu_endereco[1:0]);
                        cpu_dado_lido   <= '0;
                    end
                end
                ACESSO0: begin
                    if (mem_ack) begin
                        if (!pedido.escrita && pedido.tamanho == TAM_PALAVRA) begin
                            metade_baixa <= mem_dado_leitura;
                        end else if (!pedido.escrita) begin
                            cpu_dado_lido <= {{(LARGURA_DADO-LARGURA_MEIA){mem_dado_leitura[LARGURA_MEIA-1]}},
                                              mem_dado_leitura};
                        end
                    end else if (expirou) begin
                        cpu_erro      <= 1'b1;
                        cpu_dado_lido <= '0;
                    end
                end
                ACESSO1: begin
                    if (mem_ack) begin
                        if (!pedido.escrita) begin
                            cpu_dado_lido <= {mem_dado_leitura, metade_baixa};
                        end
                    end else if (expirou) begin
                        cpu_erro      <= 1'b1;
                        cpu_dado_lido <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_load_store.sv
// Bench for unidade_load_store: directed cases plus random accesses against a halfword memory model.
module tb_unidade_load_store;

    localparam int T = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_escrita;
    logic        cpu_tamanho;
    logic [31:0] cpu_endereco;
    logic [31:0] cpu_dado;
    logic        cpu_ocupado;
    logic        cpu_pronto;
    logic        cpu_erro;
    logic [31:0] cpu_dado_lido;
    logic        mem_req;
    logic        mem_escrita;
    logic [31:0] mem_endereco;
    logic [15:0] mem_dado_escrita;
    logic        mem_ack;
    logic [15:0] mem_dado_leitura;

    logic [15:0] memoria [0:255];
    int testes = 0;
    int falhas = 0;

    unidade_load_store #(.TIMEOUT_CICLOS(T)) dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_req          (cpu_req),
        .cpu_escrita      (cpu_escrita),
        .cpu_tamanho      (cpu_tamanho),
        .cpu_endereco     (cpu_endereco),
        .cpu_dado         (cpu_dado),
        .cpu_ocupado      (cpu_ocupado),
        .cpu_pronto       (cpu_pronto),
        .cpu_erro         (cpu_erro),
        .cpu_dado_lido    (cpu_dado_lido),
        .mem_req          (mem_req),
        .mem_escrita      (mem_escrita),
        .mem_endereco     (mem_endereco),
        .mem_dado_escrita (mem_dado_escrita),
        .mem_ack          (mem_ack),
        .mem_dado_leitura (mem_dado_leitura)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        testes++;
        assert (obs === esp) else begin
            falhas++;
            $error("FAIL %s: observed %h expected %h", tag, obs, esp);
        end
    endtask

    task automatic verifica_ocioso(input string tag);
        verifica({tag, "/ocupado"},       32'(cpu_ocupado), 32'd0);
        verifica({tag, "/pronto"},        32'(cpu_pronto), 32'd0);
        verifica({tag, "/mem_req"},       32'(mem_req), 32'd0);
        verifica({tag, "/mem_escrita"},   32'(mem_escrita), 32'd0);
        verifica({tag, "/mem_endereco"},  mem_endereco, 32'd0);
        verifica({tag, "/mem_dado"},      32'(mem_dado_escrita), 32'd0);
        verifica({tag, "/erro"},          32'(cpu_erro), 32'd0);
        verifica({tag, "/dado_lido"},     cpu_dado_lido, 32'd0);
    endtask

    // One CPU request from issue to completion; the bench acts as memory with a0/a1 wait cycles per half.
    task automatic transacao(input string tag, input logic escrita, input logic tamanho,
                             input logic [31:0] endereco, input logic [31:0] dado,
                             input int a0, input int a1, input bit pulso_ocupado);
        logic [31:0] e1, esp_dado, esp_end;
        logic [7:0]  i0, i1;
        logic        esp_erro, desal, fim;
        int          esp_lat, esp_acessos, n_acessos, espera, ciclos, acc, iniciados, atr;
        int          atraso [2];

        e1 = endereco + 32'd2;
        i0 = endereco[8:1];
        i1 = e1[8:1];
        atraso[0] = a0;
        atraso[1] = a1;
        desal = tamanho ? (endereco[1:0] != 2'b00) : endereco[0];
        n_acessos = tamanho ? 2 : 1;
        esp_erro = 1'b0;
        esp_lat = 1;
        esp_acessos = 0;
        if (desal) begin
            esp_erro = 1'b1;
        end else begin
            for (int k = 0; k < n_acessos; k++) begin
                esp_acessos++;
                if (atraso[k] >= T) begin
                    esp_lat += T;
                    esp_erro = 1'b1;
                    break;
                end
                esp_lat += atraso[k] + 1;
            end
        end
        if (esp_erro || escrita)  esp_dado = 32'd0;
        else if (tamanho)         esp_dado = {memoria[i1], memoria[i0]};
        else                      esp_dado = {{16{memoria[i0][15]}}, memoria[i0]};

        cpu_req = 1'b1;
        cpu_escrita = escrita;
        cpu_tamanho = tamanho;
        cpu_endereco = endereco;
        cpu_dado = dado;
        mem_ack = 1'b0;
        ciclos = 0;
        acc = 0;
        iniciados = 0;
        espera = 0;
        fim = 1'b0;
        while (!fim && ciclos < 60) begin
            @(negedge clock);
            ciclos++;
            cpu_req = pulso_ocupado && (ciclos == 1);
            if (pulso_ocupado && ciclos == 1) begin
                cpu_endereco = endereco ^ 32'h0000_0100;
                cpu_dado = ~dado;
            end
            mem_ack = 1'b0;
            mem_dado_leitura = 16'($urandom);
            verifica({tag, "/ocupado"}, 32'(cpu_ocupado), 32'd1);
            if (cpu_pronto) begin
                fim = 1'b1;
                verifica({tag, "/mem_req_no_fim"}, 32'(mem_req), 32'd0);
            end else if (mem_req) begin
                if (espera == 0) begin
                    verifica({tag, "/acesso_extra"}, 32'(iniciados < esp_acessos), 32'd1);
                    iniciados++;
                end
                esp_end = (acc == 0) ? endereco : e1;
                verifica({tag, "/mem_endereco"}, mem_endereco, esp_end);
                verifica({tag, "/mem_escrita"}, 32'(mem_escrita), 32'(escrita));
                verifica({tag, "/mem_dado_escrita"}, 32'(mem_dado_escrita),
                         (acc == 0) ? 32'(dado[15:0]) : 32'(dado[31:16]));
                atr = (acc < 2) ? atraso[acc] : 0;
                if (espera >= atr) begin
                    mem_ack = 1'b1;
                    if (escrita) memoria[esp_end[8:1]] = mem_dado_escrita;
                    else         mem_dado_leitura = memoria[esp_end[8:1]];
                    acc++;
                    espera = 0;
                end else begin
                    espera++;
                end
            end
        end
        mem_ack = 1'b0;
        cpu_req = 1'b0;
        if (!fim) begin
            verifica({tag, "/pronto_limite"}, 32'(cpu_pronto), 32'd1);
        end else begin
            verifica({tag, "/latencia"}, 32'(ciclos), 32'(esp_lat));
            verifica({tag, "/erro"}, 32'(cpu_erro), 32'(esp_erro));
            verifica({tag, "/dado_lido"}, cpu_dado_lido, esp_dado);
            verifica({tag, "/acessos"}, 32'(iniciados), 32'(esp_acessos));
            @(negedge clock);
            verifica({tag, "/pronto_pulso"}, 32'(cpu_pronto), 32'd0);
            verifica({tag, "/ocioso"}, 32'(cpu_ocupado), 32'd0);
            verifica({tag, "/mem_req_ocioso"}, 32'(mem_req), 32'd0);
            verifica({tag, "/erro_mantido"}, 32'(cpu_erro), 32'(esp_erro));
            verifica({tag, "/dado_mantido"}, cpu_dado_lido, esp_dado);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) memoria[i] = 16'($urandom);
        memoria[3] = 16'h8001;
        reset = 1'b1;
        cpu_req = 1'b0;
        cpu_escrita = 1'b0;
        cpu_tamanho = 1'b0;
        cpu_endereco = 32'd0;
        cpu_dado = 32'd0;
        mem_ack = 1'b0;
        mem_dado_leitura = 16'd0;
        repeat (2) @(negedge clock);
        verifica_ocioso("reset_inicial");
        reset = 1'b0;
        @(negedge clock);

        transacao("meia_0x6", 1'b0, 1'b0, 32'h0000_0006, 32'd0, 0, 0, 1'b0);
        verifica("meia_0x6/valor", cpu_dado_lido, 32'hFFFF_8001);

        transacao("palavra_store", 1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 3, 3, 1'b0);
        verifica("palavra_store/baixa", 32'(memoria[8]), 32'h0000_5678);
        verifica("palavra_store/alta", 32'(memoria[9]), 32'h0000_1234);

        transacao("palavra_desalinhada", 1'b0, 1'b1, 32'h0000_0002, 32'd0, 0, 0, 1'b0);
        transacao("meia_desalinhada", 1'b1, 1'b0, 32'h0000_0031, 32'hCAFE_BABE, 0, 0, 1'b0);

        transacao("timeout_load", 1'b0, 1'b0, 32'h0000_0020, 32'd0, 99, 0, 1'b0);
        transacao("ack_no_limite", 1'b0, 1'b0, 32'h0000_0022, 32'd0, T - 1, 0, 1'b0);
        transacao("palavra_ack_limite", 1'b0, 1'b1, 32'h0000_0024, 32'd0, T - 1, T - 1, 1'b0);

        memoria[16'h40 >> 1] = 16'h0000;
        transacao("store_timeout_alta", 1'b1, 1'b1, 32'h0000_0040, 32'hAAAA_5555, 0, 99, 1'b0);
        verifica("store_timeout_alta/baixa_gravada", 32'(memoria[16'h40 >> 1]), 32'h0000_5555);

        // Word load interrupted by reset while the high half is outstanding.
        cpu_req = 1'b1;
        cpu_escrita = 1'b0;
        cpu_tamanho = 1'b1;
        cpu_endereco = 32'h0000_0060;
        @(negedge clock);
        cpu_req = 1'b0;
        verifica("reset_meio/acesso0", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        mem_dado_leitura = 16'hBEEF;
        @(negedge clock);
        mem_ack = 1'b0;
        verifica("reset_meio/acesso1_req", 32'(mem_req), 32'd1);
        verifica("reset_meio/acesso1_end", mem_endereco, 32'h0000_0062);
        reset = 1'b1;
        @(negedge clock);
        verifica_ocioso("reset_meio");
        reset = 1'b0;

        // Reset wins over a simultaneous request and ack.
        reset = 1'b1;
        cpu_req = 1'b1;
        cpu_tamanho = 1'b0;
        cpu_endereco = 32'h0000_0004;
        mem_ack = 1'b1;
        @(negedge clock);
        verifica_ocioso("reset_prioridade");
        reset = 1'b0;
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        @(negedge clock);
        verifica("reset_prioridade/sem_aceite", 32'(cpu_ocupado), 32'd0);

        transacao("req_ocupado", 1'b0, 1'b0, 32'h0000_0008, 32'd0, 3, 0, 1'b1);
        repeat (3) begin
            @(negedge clock);
            verifica("req_ocupado/sem_segundo_req", 32'(mem_req), 32'd0);
            verifica("req_ocupado/sem_segundo_ocupado", 32'(cpu_ocupado), 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            logic        esc, tam;
            logic [31:0] e, d;
            int          r0, r1;
            esc = 1'($urandom_range(0, 1));
            tam = 1'($urandom_range(0, 1));
            e = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                e[1:0] = tam ? 2'b00 : {1'($urandom_range(0, 1)), 1'b0};
            end
            d = $urandom;
            r0 = ($urandom_range(0, 9) == 0) ? T + 4 : int'($urandom_range(0, 4));
            r1 = ($urandom_range(0, 9) == 0) ? T + 4 : int'($urandom_range(0, 4));
            transacao("aleatoria", esc, tam, e, d, r0, r1, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
